// File: rtl/vic_intr_cond.sv
// vic_intr_cond: interrupt source conditioner feeding the VIC.
// Each source is synchronised, polarity-adjusted, and then passed through as a
// level or latched as an edge into a software-clearable pending bit. A small
// register window on the peripheral bus provides configuration and status.
module vic_intr_cond #(
  parameter int unsigned NUM_SRC     = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFFE000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_intr,
  input  logic [31:0]        bus_addr,
  input  logic               bus_wr,
  input  logic               bus_en,
  input  logic [31:0]        bus_data_i,
  output logic [31:0]        bus_data_o,
  input  logic               is_priviledge,
  output logic [31:0]        vic_intr
);

  // Bits at or above NUM_SRC are tied off everywhere through this mask.
  localparam logic [63:0] MASK64   = (64'd1 << NUM_SRC) - 64'd1;
  localparam logic [31:0] SRC_MASK = MASK64[31:0];

  // Register word indices within the window.
  localparam logic [2:0] IDX_EDGE_SEL = 3'd0;
  localparam logic [2:0] IDX_POLARITY = 3'd1;
  localparam logic [2:0] IDX_PENDING  = 3'd2;
  localparam logic [2:0] IDX_PEND_CLR = 3'd3;
  localparam logic [2:0] IDX_RAW_SYNC = 3'd4;
  localparam logic [2:0] IDX_PROTECT  = 3'd5;

  // State
  logic [31:0] sync_q [SYNC_STAGES];
  logic [31:0] sd_q;
  logic [31:0] edge_sel_q, edge_sel_d;
  logic [31:0] polarity_q, polarity_d;
  logic [31:0] pending_q,  pending_d;
  logic        protect_q,  protect_d;
  logic [31:0] vic_q,      vic_d;
  logic [31:0] rdata_q,    rdata_d;

  // Combinational helpers
  logic [31:0] src_ext;
  logic [31:0] s;
  logic [31:0] a;
  logic [31:0] ad;
  logic [31:0] edge_ev;
  logic [31:0] clr_mask;
  logic [31:0] offset;
  logic [2:0]  idx;
  logic        hit;
  logic        wr_ok;
  logic        rd_ok;

  assign bus_data_o = rdata_q;
  assign vic_intr   = vic_q;

  // Zero-extend the raw source lines to the 32-bit internal datapath.
  always_comb begin
    src_ext              = '0;
    src_ext[NUM_SRC-1:0] = src_intr;
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Address decode: word-aligned accesses inside the 32-byte window only.
  always_comb begin
    offset = bus_addr - BASE_ADDR;
    hit    = (offset[31:5] == '0) && (offset[1:0] == 2'b00);
    idx    = offset[4:2];
    wr_ok  = bus_en && bus_wr && hit && (!protect_q || is_priviledge);
    rd_ok  = bus_en && !bus_wr;
  end

  // Configuration next-state, edge detection, pending and output request logic.
  always_comb begin
    edge_sel_d = edge_sel_q;
    polarity_d = polarity_q;
    protect_d  = protect_q;
    clr_mask   = '0;

    if (wr_ok) begin
      unique case (idx)
        IDX_EDGE_SEL: edge_sel_d = bus_data_i & SRC_MASK;
        IDX_POLARITY: polarity_d = bus_data_i & SRC_MASK;
        IDX_PEND_CLR: clr_mask   = bus_data_i & SRC_MASK;
        IDX_PROTECT:  protect_d  = bus_data_i[0];
        default:      ;
      endcase
    end

    // Both a and ad use the incoming polarity, which is equivalent to flipping
    // sd for the changed bits: a polarity write alone never looks like an edge.
    a  = (s    ^ polarity_d) & SRC_MASK;
    ad = (sd_q ^ polarity_d) & SRC_MASK;

    edge_ev = a & ~ad & edge_sel_q;

    // Set wins over a same-cycle clear; a mode change then overrides both.
    pending_d = (pending_q & ~clr_mask) | edge_ev;
    pending_d = pending_d & ~(edge_sel_d ^ edge_sel_q) & SRC_MASK;

    vic_d = ((edge_sel_q & pending_d) | (~edge_sel_q & a)) & SRC_MASK;
  end

  // Read data mux; the registered copy only moves on a read strobe.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_ok) begin
      rdata_d = '0;
      if (hit) begin
        unique case (idx)
          IDX_EDGE_SEL: rdata_d = edge_sel_q;
          IDX_POLARITY: rdata_d = polarity_q;
          IDX_PENDING:  rdata_d = pending_q;
          IDX_RAW_SYNC: rdata_d = s & SRC_MASK;
          IDX_PROTECT:  rdata_d = {31'd0, protect_q};
          default:      rdata_d = '0;
        endcase
      end
    end
  end

  // Synchroniser chain and the one-cycle delayed copy of its last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      sd_q <= '0;
    end else begin
      sync_q[0] <= src_ext & SRC_MASK;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      sd_q <= s;
    end
  end

  // Configuration, pending, output request and read data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_sel_q <= '0;
      polarity_q <= '0;
      pending_q  <= '0;
      protect_q  <= 1'b0;
      vic_q      <= '0;
      rdata_q    <= '0;
    end else begin
      edge_sel_q <= edge_sel_d;
      polarity_q <= polarity_d;
      pending_q  <= pending_d;
      protect_q  <= protect_d;
      vic_q      <= vic_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_vic_intr_cond.sv
// tb_vic_intr_cond: directed checks for the interrupt source conditioner.
module tb_vic_intr_cond;

  localparam logic [31:0] BASE = 32'hFFFFE000;
  localparam logic [31:0] A_EDGE_SEL = BASE + 32'h00;
  localparam logic [31:0] A_POLARITY = BASE + 32'h04;
  localparam logic [31:0] A_PENDING  = BASE + 32'h08;
  localparam logic [31:0] A_PEND_CLR = BASE + 32'h0C;
  localparam logic [31:0] A_RAW_SYNC = BASE + 32'h10;
  localparam logic [31:0] A_PROTECT  = BASE + 32'h14;
  localparam logic [31:0] A_RSVD     = BASE + 32'h18;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_intr;
  logic [31:0] bus_addr;
  logic        bus_wr;
  logic        bus_en;
  logic [31:0] bus_data_i;
  logic [31:0] bus_data_o;
  logic        is_priviledge;
  logic [31:0] vic_intr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vic_intr_cond #(
    .NUM_SRC    (32),
    .SYNC_STAGES(2),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_intr     (src_intr),
    .bus_addr     (bus_addr),
    .bus_wr       (bus_wr),
    .bus_en       (bus_en),
    .bus_data_i   (bus_data_i),
    .bus_data_o   (bus_data_o),
    .is_priviledge(is_priviledge),
    .vic_intr     (vic_intr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic priv);
    bus_addr      = addr;
    bus_data_i    = data;
    bus_wr        = 1'b1;
    bus_en        = 1'b1;
    is_priviledge = priv;
    tick();
    bus_en        = 1'b0;
    bus_wr        = 1'b0;
    is_priviledge = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus_addr = addr;
    bus_wr   = 1'b0;
    bus_en   = 1'b1;
    tick();
    bus_en   = 1'b0;
    data     = bus_data_o;
  endtask

  logic [31:0] rd;

  initial begin
    rst           = 1'b1;
    src_intr      = '1;
    bus_addr      = '0;
    bus_wr        = 1'b0;
    bus_en        = 1'b0;
    bus_data_i    = '0;
    is_priviledge = 1'b0;

    // 1: reset with all sources high; a write during reset is discarded
    tick();
    bus_write(A_EDGE_SEL, 32'h0000_00FF, 1'b1);
    tick();
    check_eq("rst_vic", vic_intr, 32'h0);
    check_eq("rst_rdata", bus_data_o, 32'h0);
    rst = 1'b0;
    bus_read(A_PENDING, rd);
    check_eq("rst_pending", rd, 32'h0);
    bus_read(A_EDGE_SEL, rd);
    check_eq("rst_edge_sel", rd, 32'h0);
    src_intr = '0;
    ticks(5);
    check_eq("idle_vic", vic_intr, 32'h0);

    // 2: level mode, rising then falling on src 3, three-edge latency
    src_intr[3] = 1'b1;
    ticks(2);
    check_eq("lvl_rise_e2", vic_intr, 32'h0);
    tick();
    check_eq("lvl_rise_e3", vic_intr, 32'h0000_0008);
    src_intr[3] = 1'b0;
    ticks(2);
    check_eq("lvl_fall_e2", vic_intr, 32'h0000_0008);
    tick();
    check_eq("lvl_fall_e3", vic_intr, 32'h0);

    // 3: edge mode on src 0, 2-cycle pulse latches, then software clear
    bus_write(A_EDGE_SEL, 32'h1, 1'b0);
    src_intr[0] = 1'b1;
    ticks(2);
    src_intr[0] = 1'b0;
    check_eq("edge_e2", vic_intr, 32'h0);
    tick();
    check_eq("edge_e3", vic_intr, 32'h1);
    ticks(4);
    check_eq("edge_hold", vic_intr, 32'h1);
    bus_read(A_PENDING, rd);
    check_eq("edge_pending", rd, 32'h1);
    bus_write(A_PEND_CLR, 32'h1, 1'b0);
    check_eq("edge_clr_vic", vic_intr, 32'h0);
    bus_read(A_PENDING, rd);
    check_eq("edge_clr_pending", rd, 32'h0);
    bus_read(A_PEND_CLR, rd);
    check_eq("pend_clr_reads0", rd, 32'h0);

    // 4: clear in the same cycle as a new edge event -> set wins
    src_intr[0] = 1'b1;
    ticks(2);
    bus_write(A_PEND_CLR, 32'h1, 1'b0);
    check_eq("setwin_vic", vic_intr, 32'h1);
    bus_read(A_PENDING, rd);
    check_eq("setwin_pending", rd, 32'h1);
    src_intr[0] = 1'b0;
    ticks(4);
    bus_write(A_PEND_CLR, 32'h1, 1'b0);
    bus_read(A_PENDING, rd);
    check_eq("setwin_cleanup", rd, 32'h0);

    // 5: write protection
    bus_write(A_PROTECT, 32'hFFFF_FFFF, 1'b0);
    bus_read(A_PROTECT, rd);
    check_eq("protect_rd", rd, 32'h1);
    bus_write(A_EDGE_SEL, 32'h0000_FFFF, 1'b0);
    bus_read(A_EDGE_SEL, rd);
    check_eq("prot_blocked", rd, 32'h1);
    bus_write(A_EDGE_SEL, 32'h0000_FFFF, 1'b1);
    bus_read(A_EDGE_SEL, rd);
    check_eq("prot_allowed", rd, 32'h0000_FFFF);
    bus_write(A_EDGE_SEL, 32'h0000_0020, 1'b1);
    bus_write(A_PROTECT, 32'h0, 1'b1);
    bus_read(A_PROTECT, rd);
    check_eq("protect_off", rd, 32'h0);

    // 6: polarity flip on an idle edge source is not an edge; a falling edge is
    bus_write(A_POLARITY, 32'h0000_0020, 1'b0);
    ticks(4);
    bus_read(A_PENDING, rd);
    check_eq("polflip_pending", rd, 32'h0);
    check_eq("polflip_vic", vic_intr, 32'h0);
    src_intr[5] = 1'b1;
    ticks(4);
    bus_read(A_PENDING, rd);
    check_eq("pol_rise_ignored", rd, 32'h0);
    src_intr[5] = 1'b0;
    ticks(4);
    bus_read(A_PENDING, rd);
    check_eq("pol_fall_pending", rd, 32'h0000_0020);
    check_eq("pol_fall_vic", vic_intr, 32'h0000_0020);

    // Mode change clears pending for the changed bit
    bus_write(A_EDGE_SEL, 32'h0, 1'b0);
    bus_read(A_PENDING, rd);
    check_eq("modechg_clr", rd, 32'h0);

    // Level mode with polarity, RAW_SYNC, reserved and out-of-window reads
    src_intr = 32'hA5A5_0000;
    ticks(3);
    check_eq("lvl_pol_vic", vic_intr, 32'hA5A5_0020);
    bus_read(A_RAW_SYNC, rd);
    check_eq("raw_sync", rd, 32'hA5A5_0000);
    bus_read(A_RSVD, rd);
    check_eq("reserved_rd", rd, 32'h0);
    bus_read(BASE + 32'h20, rd);
    check_eq("outside_rd", rd, 32'h0);
    bus_read(A_POLARITY, rd);
    check_eq("polarity_rd", rd, 32'h0000_0020);
    bus_write(BASE + 32'h20, 32'hFFFF_FFFF, 1'b1);
    tick();
    check_eq("rdata_hold", bus_data_o, 32'h0000_0020);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
